aes_key_sched_ctrl: RTL
=======================

Name: aes_key_sched_ctrl

Overview:
- Sequencer in front of the AES-128 key expansion unit.
- Accepts a 128-bit cipher key from the host as four 32-bit words over a valid/ready handshake. Replays the words to the expander in its start-plus-4-cycle load protocol, then waits for expansion done.
- Serves 128-bit round-key requests from the cipher round datapath by reading the expander's 32-bit word port four times per key.
- Detects expansion timeout and out-of-range round requests.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT_DONE before flagging an error.
- NUM_ROUNDS, 10, highest legal round-key index.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  reset.
- key_valid  in  1  host key word valid.
- key_word  in  32  host key word, most-significant word first.
- key_ready  out  1  controller accepts key_word this cycle.
- ke_start  out  1  one-cycle start pulse to expander.
- ke_cipher_key  out  32  key word to expander.
- ke_round_key_num  out  4  round-key select to expander.
- ke_r_index  out  2  word select to expander, 0 = bits 127:96.
- ke_round_key  in  32  expander word output, combinational from selects.
- ke_done  in  1  expander done, level.
- rk_req  in  1  round-key request, held until accepted.
- rk_num  in  4  requested round-key index.
- rk_req_ack  out  1  one-cycle request accept.
- rk_valid  out  1  rk_data valid.
- rk_data  out  128  assembled round key.
- rk_ready  in  1  consumer takes rk_data.
- keys_ready  out  1  expansion complete, requests serviceable.
- err  out  1  sticky error: timeout or bad rk_num.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, key buffer 0, counters 0.
- Reset mid-operation aborts everything. The expander is not re-initialised until the next full key load.

States:
- IDLE: key_ready=1. A key_valid&key_ready handshake stores word0 and moves to COLLECT.
- COLLECT: key_ready=1. Stores words 1..3 in order on each handshake. After word3, go to START.
- START: ke_start=1 for exactly 1 cycle, then go to LOAD.
- LOAD: 4 cycles. ke_cipher_key = buffer word 0,1,2,3 on consecutive cycles, then go to WAIT_DONE. ke_cipher_key=0 outside LOAD.
- WAIT_DONE: ke_done is ignored in the first cycle, because a stale done from the previous key may still be high. After that, ke_done=1 goes to READY.
  - A 16-bit counter counts cycles in this state.
  - When the count reaches TIMEOUT_CYCLES: set err and go to IDLE; keys_ready stays 0.
- READY: keys_ready=1, key_ready=1.
  - rk_req with rk_num<=NUM_ROUNDS: rk_req_ack=1 that cycle, latch rk_num, go to FETCH.
  - rk_req with rk_num>NUM_ROUNDS: rk_req_ack=1, set err, stay in READY, no fetch.
  - key_valid handshake: store word0, clear keys_ready, go to COLLECT (re-key).
  - If rk_req and key_valid arrive together, rk_req wins and key_ready=0 that cycle.
- FETCH: 4 cycles, i=0..3. ke_round_key_num=latched num, ke_r_index=i. Capture ke_round_key the same cycle into rk_data bits [127-32i -: 32], then go to PRESENT. key_ready=0.
- PRESENT: rk_valid=1 and rk_data stable until rk_valid&rk_ready, then go to READY. Latency from rk_req_ack to rk_valid is 5 cycles. key_ready=0.

Other rules:
- ke_round_key_num and ke_r_index are 0 outside FETCH.
- key_valid is ignored in START, LOAD, WAIT_DONE, FETCH and PRESENT (key_ready=0 there).
- err is cleared only by reset or by a word0 handshake starting a new key.
- keys_ready drops in the cycle after a re-key word0 is accepted.

Test Plan:
- Load FIPS-197 key 2b7e1516,28aed2a6,abf71588,09cf4f3c with a golden expander model.
  - ke_start 1 cycle after the 4th handshake.
  - ke_cipher_key sequence matches the 4 words on the next 4 cycles.
  - keys_ready rises after ke_done.
- rk_req rk_num=1 -> rk_req_ack, then rk_valid 5 cycles later with rk_data=a0fafe1788542cb123a339392a6c7605. Hold rk_ready=0 for 3 cycles -> data stable.
- rk_num=10 -> rk_data=d014f9a8c9ee2589e13f0cc8b6630ca6. rk_num=0 -> the cipher key.
- rk_num=11 -> rk_req_ack, err=1, no rk_valid, state remains READY, keys_ready=1.
- Expander model never asserts done -> err=1 after 64 WAIT_DONE cycles, keys_ready=0, key_ready=1. A new key load clears err.
- Other:
  - Stale ke_done=1 held through re-key -> no early keys_ready.
  - Reset_n low during FETCH -> all outputs 0 immediately.
  - Simultaneous rk_req and key_valid in READY -> request served, key word not accepted.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//
// Sequencer in front of an AES-128 key expansion unit. It collects a 128-bit
// cipher key from the host as four 32-bit words, replays them to the expander
// (start pulse followed by four load cycles) and waits for expansion done.
// Once the schedule is ready it serves 128-bit round-key requests by reading
// the expander's 32-bit word port four times per key.
//
// Ports:
//   clk, reset_n         single clock, asynchronous active-low reset
//   key_valid/key_word   host key word stream (MS word first)
//   key_ready            controller accepts key_word this cycle
//   ke_start             one-cycle start pulse to the expander
//   ke_cipher_key        key word presented during the load cycles
//   ke_round_key_num     round-key select to the expander (fetch only)
//   ke_r_index           word select to the expander, 0 = bits 127:96
//   ke_round_key         expander word output (combinational from selects)
//   ke_done              expander done (level)
//   rk_req/rk_num        round-key request, held until rk_req_ack
//   rk_req_ack           one-cycle request accept
//   rk_valid/rk_data     assembled round key, held until rk_ready
//   keys_ready           schedule complete, requests serviceable
//   err                  sticky: expansion timeout or out-of-range rk_num
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned NUM_ROUNDS     = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_valid,
    input  logic [31:0]  key_word,
    output logic         key_ready,
    output logic         ke_start,
    output logic [31:0]  ke_cipher_key,
    output logic [3:0]   ke_round_key_num,
    output logic [1:0]   ke_r_index,
    input  logic [31:0]  ke_round_key,
    input  logic         ke_done,
    input  logic         rk_req,
    input  logic [3:0]   rk_num,
    output logic         rk_req_ack,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    input  logic         rk_ready,
    output logic         keys_ready,
    output logic         err
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_ROUND   = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_START,
        S_LOAD,
        S_WAIT_DONE,
        S_READY,
        S_FETCH,
        S_PRESENT
    } state_t;

    state_t            state;
    logic [3:0][31:0]  key_buf;      // key_buf[0] is the first (MS) word
    logic [1:0]        word_cnt;     // word position while collecting / loading
    logic [15:0]       wait_cnt;     // cycles spent in WAIT_DONE
    logic              key_ready_q;  // registered "state accepts key words"
    logic              key_hs;

    // A pending round-key request in READY takes priority over a key word,
    // so the key side is refused in that same cycle.
    assign rk_req_ack = (state == S_READY) && rk_req;
    assign key_ready  = key_ready_q && !rk_req_ack;
    assign key_hs     = key_valid && key_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            key_buf          <= '0;
            word_cnt         <= '0;
            wait_cnt         <= '0;
            key_ready_q      <= 1'b0;
            ke_start         <= 1'b0;
            ke_cipher_key    <= '0;
            ke_round_key_num <= '0;
            ke_r_index       <= '0;
            rk_valid         <= 1'b0;
            rk_data          <= '0;
            keys_ready       <= 1'b0;
            err              <= 1'b0;
        end else begin
            ke_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    key_ready_q <= 1'b1;
                    if (key_hs) begin
                        key_buf[0] <= key_word;
                        word_cnt   <= 2'd1;
                        err        <= 1'b0;
                        state      <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (key_hs) begin
                        key_buf[word_cnt] <= key_word;
                        if (word_cnt == 2'd3) begin
                            word_cnt    <= 2'd0;
                            key_ready_q <= 1'b0;
                            ke_start    <= 1'b1;
                            state       <= S_START;
                        end else begin
                            word_cnt <= word_cnt + 2'd1;
                        end
                    end
                end

                S_START: begin
                    ke_cipher_key <= key_buf[0];
                    state         <= S_LOAD;
                end

                // ke_cipher_key already shows key_buf[word_cnt] this cycle
                S_LOAD: begin
                    if (word_cnt == 2'd3) begin
                        ke_cipher_key <= '0;
                        word_cnt      <= 2'd0;
                        wait_cnt      <= '0;
                        state         <= S_WAIT_DONE;
                    end else begin
                        ke_cipher_key <= key_buf[word_cnt + 2'd1];
                        word_cnt      <= word_cnt + 2'd1;
                    end
                end

                // The first cycle ignores ke_done: a done level left over from
                // the previous key can still be high before the expander reacts.
                S_WAIT_DONE: begin
                    if ((wait_cnt != 16'd0) && ke_done) begin
                        keys_ready  <= 1'b1;
                        key_ready_q <= 1'b1;
                        state       <= S_READY;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        err         <= 1'b1;
                        key_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                S_READY: begin
                    if (rk_req) begin
                        if (rk_num <= LAST_ROUND) begin
                            ke_round_key_num <= rk_num;
                            ke_r_index       <= 2'd0;
                            key_ready_q      <= 1'b0;
                            state            <= S_FETCH;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (key_hs) begin
                        key_buf[0] <= key_word;
                        word_cnt   <= 2'd1;
                        err        <= 1'b0;
                        keys_ready <= 1'b0;
                        state      <= S_COLLECT;
                    end
                end

                S_FETCH: begin
                    case (ke_r_index)
                        2'd0:    rk_data[127:96] <= ke_round_key;
                        2'd1:    rk_data[95:64]  <= ke_round_key;
                        2'd2:    rk_data[63:32]  <= ke_round_key;
                        default: rk_data[31:0]   <= ke_round_key;
                    endcase
                    if (ke_r_index == 2'd3) begin
                        ke_round_key_num <= '0;
                        ke_r_index       <= '0;
                        rk_valid         <= 1'b1;
                        state            <= S_PRESENT;
                    end else begin
                        ke_r_index <= ke_r_index + 2'd1;
                    end
                end

                S_PRESENT: begin
                    if (rk_ready) begin
                        rk_valid    <= 1'b0;
                        key_ready_q <= 1'b1;
                        state       <= S_READY;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
